// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   nibble_t  : one hex digit
//   seg_t     : segments a..g on bits 0..6, active-high
//   SEG_OFF   : all segments dark (active-high sense)
//   SEG_TABLE : active-high gfedcba patterns for hex 0..F
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex digit to seven-segment decoder, active-high output.
//   nib : hex digit 0..F
//   seg : segments a..g on seg[0]..seg[6], 1 = lit
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a p_ndigits-digit seven-segment display.
// A new value is taken over a val/rdy handshake into a pending buffer and
// copied to the displayed buffer only at a frame boundary, so a frame never
// mixes two values. Each digit slot opens with a short blanking gap, and
// leading zeros can optionally be suppressed.
//   clk      : clock
//   rst      : synchronous active-high reset
//   in_val   : new display value valid
//   in_rdy   : pending buffer empty
//   in_data  : nibble k = in_data[4k+3:4k] is digit k (digit 0 rightmost)
//   in_lz_en : leading-zero blanking for this value
//   seg      : segments a..g on seg[0]..seg[6]
//   an       : digit enables, an[k] drives digit k
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned p_ndigits      = 4,
  parameter int unsigned p_scan_div     = 1000,
  parameter int unsigned p_blank_cycles = 2,
  parameter int unsigned p_active_low   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [4*p_ndigits-1:0] in_data,
  input  logic                   in_lz_en,
  output logic [6:0]             seg,
  output logic [p_ndigits-1:0]   an
);

  localparam int unsigned DIV_W = (p_scan_div > 1) ? $clog2(p_scan_div) : 1;
  localparam int unsigned DIG_W = (p_ndigits > 1) ? $clog2(p_ndigits) : 1;

  logic [DIV_W-1:0]       div_cnt;
  logic [DIG_W-1:0]       dig_idx;
  logic [4*p_ndigits-1:0] disp_data;
  logic                   disp_lz;
  logic [4*p_ndigits-1:0] pend_data;
  logic                   pend_lz;
  logic                   pend_full;

  logic                   div_last;
  logic                   dig_last;
  logic                   frame_end;

  nibble_t                disp_nib [p_ndigits];
  logic [p_ndigits-1:0]   zero_from;
  nibble_t                cur_nib;
  seg_t                   dec_seg;
  logic                   in_blank;
  logic                   lz_blank;
  logic                   lit;
  seg_t                   seg_h;
  logic [p_ndigits-1:0]   an_h;

  assign div_last  = (div_cnt == DIV_W'(p_scan_div - 1));
  assign dig_last  = (dig_idx == DIG_W'(p_ndigits - 1));
  assign frame_end = div_last && dig_last;
  assign in_rdy    = !pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      dig_idx   <= '0;
      disp_data <= '0;
      disp_lz   <= 1'b0;
      pend_data <= '0;
      pend_lz   <= 1'b0;
      pend_full <= 1'b0;
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
      if (div_last) begin
        dig_idx <= dig_last ? '0 : dig_idx + DIG_W'(1);
      end
      // A full pending buffer holds in_rdy low, so a frame-boundary swap and
      // a new accept can never coincide.
      if (frame_end && pend_full) begin
        disp_data <= pend_data;
        disp_lz   <= pend_lz;
        pend_full <= 1'b0;
      end else if (in_val && !pend_full) begin
        pend_data <= in_data;
        pend_lz   <= in_lz_en;
        pend_full <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < p_ndigits; k++) begin
      disp_nib[k] = disp_data[4*k +: 4];
    end
  end

  // zero_from[k]: nibbles k..p_ndigits-1 are all zero.
  always_comb begin
    zero_from = '1;
    for (int unsigned k = 0; k < p_ndigits; k++) begin
      for (int unsigned j = k; j < p_ndigits; j++) begin
        if (disp_nib[j] != 4'h0) begin
          zero_from[k] = 1'b0;
        end
      end
    end
  end

  assign cur_nib  = disp_nib[dig_idx];
  assign in_blank = (div_cnt < DIV_W'(p_blank_cycles));
  assign lz_blank = disp_lz && (dig_idx != '0) && zero_from[dig_idx];
  assign lit      = !in_blank && !lz_blank;

  hex_to_seven_seg u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  always_comb begin
    an_h  = '0;
    seg_h = SEG_OFF;
    if (lit) begin
      an_h[dig_idx] = 1'b1;
      seg_h         = dec_seg;
    end
  end

  assign seg = (p_active_low != 0) ? ~seg_h : seg_h;
  assign an  = (p_active_low != 0) ? ~an_h  : an_h;

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for a p_ndigits-digit common-anode seven-segment display.
- Accepts a packed vector of 4-bit hex nibbles over a val/rdy handshake and double-buffers it so updates land only on frame boundaries (no tearing).
- Scans one digit at a time with a blanking gap between digit slots, optionally suppressing leading zeros.
- Successor to the single-digit 0–9 decoder: full hex 0–F, N digits, sequential scanning.

Parameters:
p_ndigits, 4, number of digits scanned; must be ≥1
p_scan_div, 1000, clock cycles per digit slot; must be ≥ p_blank_cycles+1
p_blank_cycles, 2, cycles at the start of each slot with all anodes inactive
p_active_low, 1, 1: seg and an are active-low; 0: active-high

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_val  input  1  new display value valid
in_rdy  output  1  pending buffer empty, can accept
in_data  input  4*p_ndigits  nibble k = in_data[4k+3:4k] = digit k (digit 0 rightmost)
in_lz_en  input  1  leading-zero blanking for this value, captured with in_data
seg  output  7  segments a..g on seg[0]..seg[6]
an  output  p_ndigits  digit enables, an[k] drives digit k

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- State registers:
  - div_cnt: 0..p_scan_div-1
  - dig_idx: 0..p_ndigits-1
  - disp_data/disp_lz: displayed value
  - pend_data/pend_lz/pend_full: pending value
  - Widths via $clog2, minimum 1 bit.
- Reset: all registers 0; in_rdy=1; an all inactive; seg all off. With p_active_low=1 that is seg=7'h7F, an=all ones. Shown value after reset is 0, lz off.
- Counting: div_cnt increments every cycle and wraps at p_scan_div-1. On wrap, dig_idx increments, wrapping at p_ndigits-1.
- Frame boundary (FB): the cycle with div_cnt==p_scan_div-1 && dig_idx==p_ndigits-1.
- Handshake:
  - in_rdy = !pend_full, from a register only; no combinational path from in_val.
  - Transfer when in_val && in_rdy: pend_data<=in_data, pend_lz<=in_lz_en, pend_full<=1.
  - in_data is ignored when no transfer occurs.
- At FB with pend_full: disp<=pend, pend_full<=0. in_rdy rises the next cycle. At FB, in_rdy is necessarily 0, so there is no accept/transfer conflict.
- Latency: a value accepted in any cycle up to and including the cycle before FB is first displayed in the slot for digit 0 that starts the cycle after that FB.
- Throughput: at most one new value per frame.
- Outputs are combinational functions of registered state only; no input-to-output path.
- Blanking:
  - During slot cycles div_cnt < p_blank_cycles, an is all inactive and seg is all off.
  - Otherwise an is one-hot on dig_idx and seg = decode(disp nibble dig_idx).
- Leading-zero blanking (disp_lz=1): digit k>0 is blanked for its whole slot (an inactive, seg off) if nibbles k..p_ndigits-1 are all zero. Digit 0 is never suppressed, so value 0 shows a single "0".
- Decode table, active-high gfedcba:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
  - With p_active_low=1, seg and an are bitwise inverted.
- Reset mid-operation: takes effect at the next clock edge regardless of state. Pending data is discarded; the display returns to the reset condition and restarts at digit 0, div_cnt 0.
- p_ndigits=1: every slot end is FB.

Decomposition:
- Package seven_seg_pkg:
  - localparam array of the 16 active-high segment patterns
  - SEG_OFF constant
  - nibble typedef (logic [3:0]) and segment typedef (logic [6:0])
- Sub-module hex_to_seven_seg: combinational 4-bit→7-bit active-high decoder, instantiated once on the muxed nibble. Polarity inversion happens in the parent.

Test Plan:
Config for T1–T5: p_ndigits=4, p_scan_div=4, p_blank_cycles=1, p_active_low=1.
1. Reset, then idle for 16 cycles → cycle 0: an=4'b1111, seg=7'h7F. Cycles 1–3: an=4'b1110, seg=7'b1000000. Each later slot starts with 1 blank cycle, then an=1101/1011/0111, seg=1000000. in_rdy=1 throughout.
2. After reset, pulse in_val with in_data=16'h12AF, lz=0, at cycle 3 → in_rdy=0 from cycle 4 and display stays all zeros. FB at cycle 15, in_rdy=1 at 16. Cycles 17–19: an=1110, seg=7'b0001110 (F). Digit 1 shows A=0001000, digit 2 shows 2=0100100, digit 3 shows 1=1111001.
3. Hold in_val=1 continuously with changing data → exactly one accept per frame, only in cycles where in_rdy=1. Each displayed value equals the data at its accept cycle; intermediate values are dropped.
4. in_data=16'h0030, lz=1 → digits 3 and 2 are an=1111 for their full slots. Digit 1 shows 3 (0110000), digit 0 shows 0. Then data 16'h0000, lz=1 → only digit 0 is lit.
5. Assert rst for 1 cycle mid-frame with pend_full=1 → next cycle in_rdy=1, an=1111, seg=7'h7F. Display shows 0 in later slots and the old pending value never appears.
6. Config p_ndigits=2, p_scan_div=3, p_blank_cycles=1, p_active_low=0; load 8'h88 → in non-blank cycles, seg=7'h7F with an=2'b01, then 2'b10. Blank cycles show an=00, seg=00.
